// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl: single-outstanding request controller between a pipeline
// request/response port and a start/ready style memory with a shared,
// bidirectional data bus. Handles misaligned requests without touching memory,
// aborts accesses that never see memory_rdy, and waits for memory_rdy to drop
// before accepting the next request.
module mem_request_ctrl #(
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] memory_address,
  inout  wire  [31:0] memory_data,
  output logic        memory_start,
  input  logic        memory_rdy,
  output logic        memory_write_enable
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Terminal values of the start-hold and timeout counters (count from zero).
  localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_hold_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic        r_mem_start;
  logic        r_mem_we;
  logic        r_drive_en;

  logic        w_accept;
  logic        w_misaligned;

  assign w_accept     = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_misaligned = (req_address[1:0] != 2'b00);

  assign req_ready           = r_req_ready;
  assign resp_valid          = r_resp_valid;
  assign resp_error          = r_resp_error;
  assign resp_rdata          = r_resp_rdata;
  assign memory_address      = r_mem_addr;
  assign memory_start        = r_mem_start;
  assign memory_write_enable = r_mem_we;
  // The bus is only ever driven while a write access is in flight.
  assign memory_data         = r_drive_en ? r_wdata : 32'hzzzz_zzzz;

  // Request FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= 32'h0000_0000;
      r_hold_cnt   <= 4'd0;
      r_to_cnt     <= 8'd0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_start  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_drive_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_wdata     <= req_wdata;
            r_mem_addr  <= req_address;
            if (w_misaligned) begin
              // Rejected without a memory access.
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= 32'h0000_0000;
            end else begin
              r_state     <= S_START;
              r_mem_start <= 1'b1;
              r_mem_we    <= req_write;
              r_drive_en  <= req_write;
              r_hold_cnt  <= 4'd0;
              r_to_cnt    <= 8'd0;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_START, S_WAIT: begin
          if (memory_rdy) begin
            // Completion, possibly early while still strobing start.
            r_state      <= S_RESP;
            r_mem_start  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_drive_en   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            if (!r_write) begin
              r_resp_rdata <= memory_data;
            end else begin
              r_resp_rdata <= r_resp_rdata;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Memory never answered: abort with an error response.
            r_state      <= S_RESP;
            r_to_cnt     <= r_to_cnt + 8'd1;
            r_mem_start  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_drive_en   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b1;
            r_resp_rdata <= 32'h0000_0000;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
            if (r_state == S_START) begin
              if (r_hold_cnt == HOLD_LAST) begin
                r_state     <= S_WAIT;
                r_mem_start <= 1'b0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
              end
            end
          end
        end

        S_RESP: begin
          r_state      <= S_RECOVER;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
        end

        S_RECOVER: begin
          // A level-type ready must drop before a new access can start.
          if (!memory_rdy) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_mem_start  <= 1'b0;
          r_mem_we     <= 1'b0;
          r_drive_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed testbench for mem_request_ctrl. The bench acts as the memory: it
// raises memory_rdy on a chosen cycle, supplies read data from a small array,
// captures write data, and drives zero onto the shared bus whenever the
// controller is expected to have released it.
module tb_mem_request_ctrl;

  localparam int SH = 2;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        memory_rdy;
  wire         req_ready;
  wire         resp_valid;
  wire  [31:0] resp_rdata;
  wire         resp_error;
  wire  [31:0] memory_address;
  wire  [31:0] memory_data;
  wire         memory_start;
  wire         memory_write_enable;

  logic        tb_drv_en;
  logic [31:0] tb_drv_data;
  logic [31:0] tb_mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered by run_access.
  int          obs_start_cnt, obs_first_start, obs_resp_cnt, obs_resp_cyc, obs_ready_cyc;
  logic [31:0] obs_rdata;
  logic        obs_err, obs_stable_ok, obs_bus_ok, obs_acc_ok;

  assign memory_data = tb_drv_en ? tb_drv_data : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  mem_request_ctrl #(.START_HOLD(SH), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .resp_error          (resp_error),
    .memory_address      (memory_address),
    .memory_data         (memory_data),
    .memory_start        (memory_start),
    .memory_rdy          (memory_rdy),
    .memory_write_enable (memory_write_enable)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle and play memory until the controller
  // is ready again. Cycle 1 is the cycle right after the accept edge.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdy_cyc, input int rdy_len);
    int cyc;
    bit done;
    bit aligned;
    int last_cyc;
    logic [5:0] idx;
    aligned  = (addr[1:0] == 2'b00);
    last_cyc = !aligned ? 0 : ((rdy_cyc != 0) ? rdy_cyc : TO);
    idx      = addr[7:2];
    obs_start_cnt = 0; obs_first_start = 0; obs_resp_cnt = 0; obs_resp_cyc = 0;
    obs_ready_cyc = 0; obs_rdata = 32'h0; obs_err = 1'b0;
    obs_stable_ok = 1'b1; obs_bus_ok = 1'b1;
    obs_acc_ok = (req_ready === 1'b1);
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wdata;
    tick();
    // Keep a conflicting request on the port: it must be ignored while busy.
    req_write = ~wr; req_address = 32'hFFFF_FFFC; req_wdata = ~wdata;
    cyc = 1;
    done = 1'b0;
    while (!done && cyc <= 200) begin
      memory_rdy  = (rdy_cyc != 0) && (cyc >= rdy_cyc) && (cyc < rdy_cyc + rdy_len);
      tb_drv_en   = !(wr && aligned && cyc <= last_cyc);
      tb_drv_data = (memory_rdy && !wr) ? tb_mem[idx] : 32'h0000_0000;
      #1;
      if (memory_start === 1'b1) begin
        obs_start_cnt++;
        if (obs_first_start == 0) obs_first_start = cyc;
      end
      if (resp_valid === 1'b1) begin
        obs_resp_cnt++; obs_resp_cyc = cyc; obs_rdata = resp_rdata; obs_err = resp_error;
      end
      if (aligned && cyc <= last_cyc) begin
        if (memory_address !== addr || memory_write_enable !== wr || (wr && memory_data !== wdata))
          obs_stable_ok = 1'b0;
      end
      if (tb_drv_en && memory_data !== tb_drv_data) obs_bus_ok = 1'b0;
      if (wr && memory_rdy && cyc == rdy_cyc) tb_mem[idx] = memory_data;
      if (req_ready === 1'b1) begin
        done = 1'b1; obs_ready_cyc = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    memory_rdy = 1'b0; tb_drv_en = 1'b1; tb_drv_data = 32'h0000_0000; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %0h, expected 0", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0h, expected 0", resp_valid); end
    n_tests++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_resp_error: got %0h, expected 0", resp_error); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h, expected 0", resp_rdata); end
    n_tests++; if (memory_start !== 1'b0) begin n_fail++; $display("FAIL rst_memory_start: got %0h, expected 0", memory_start); end
    n_tests++; if (memory_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0h, expected 0", memory_write_enable); end
    n_tests++; if (memory_address !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0", memory_address); end
    n_tests++; if (memory_data !== 32'h0) begin n_fail++; $display("FAIL rst_bus_released: got %h, expected 0", memory_data); end
    reset = 1'b0;
    tick();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_ready: got %0h, expected 1", req_ready); end
  endtask

  task automatic test_read();
    run_access(1'b0, 32'h0000_0020, 32'h1234_5678, 5, 1);
    n_tests++; if (obs_acc_ok !== 1'b1) begin n_fail++; $display("FAIL rd_ready_at_accept: got %0h, expected 1", obs_acc_ok); end
    n_tests++; if (obs_resp_cnt != 1) begin n_fail++; $display("FAIL rd_resp_count: got %0d, expected 1", obs_resp_cnt); end
    n_tests++; if (obs_resp_cyc != 6) begin n_fail++; $display("FAIL rd_latency: got %0d, expected 6", obs_resp_cyc); end
    n_tests++; if (obs_rdata !== 32'h0016_8693) begin n_fail++; $display("FAIL rd_rdata: got %h, expected 00168693", obs_rdata); end
    n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rd_error: got %0h, expected 0", obs_err); end
    n_tests++; if (obs_start_cnt != 2) begin n_fail++; $display("FAIL rd_start_len: got %0d, expected 2", obs_start_cnt); end
    n_tests++; if (obs_first_start != 1) begin n_fail++; $display("FAIL rd_start_first: got %0d, expected 1", obs_first_start); end
    n_tests++; if (obs_stable_ok !== 1'b1) begin n_fail++; $display("FAIL rd_addr_stable: got %0h, expected 1", obs_stable_ok); end
    n_tests++; if (obs_bus_ok !== 1'b1) begin n_fail++; $display("FAIL rd_bus_released: got %0h, expected 1", obs_bus_ok); end
    n_tests++; if (obs_ready_cyc != 8) begin n_fail++; $display("FAIL rd_ready_return: got %0d, expected 8", obs_ready_cyc); end
    n_tests++; if (resp_rdata !== 32'h0016_8693) begin n_fail++; $display("FAIL rd_rdata_hold: got %h, expected 00168693", resp_rdata); end
  endtask

  task automatic test_write();
    run_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 6, 1);
    n_tests++; if (obs_resp_cnt != 1) begin n_fail++; $display("FAIL wr_resp_count: got %0d, expected 1", obs_resp_cnt); end
    n_tests++; if (obs_resp_cyc != 7) begin n_fail++; $display("FAIL wr_latency: got %0d, expected 7", obs_resp_cyc); end
    n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL wr_error: got %0h, expected 0", obs_err); end
    n_tests++; if (obs_rdata !== 32'h0016_8693) begin n_fail++; $display("FAIL wr_rdata_unchanged: got %h, expected 00168693", obs_rdata); end
    n_tests++; if (obs_stable_ok !== 1'b1) begin n_fail++; $display("FAIL wr_drive_stable: got %0h, expected 1", obs_stable_ok); end
    n_tests++; if (obs_bus_ok !== 1'b1) begin n_fail++; $display("FAIL wr_bus_released: got %0h, expected 1", obs_bus_ok); end
    n_tests++; if (tb_mem[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mem_captured: got %h, expected deadbeef", tb_mem[16]); end
    n_tests++; if (obs_ready_cyc != 9) begin n_fail++; $display("FAIL wr_ready_return: got %0d, expected 9", obs_ready_cyc); end
    run_access(1'b0, 32'h0000_0040, 32'h0000_0000, 4, 1);
    n_tests++; if (obs_resp_cyc != 5) begin n_fail++; $display("FAIL rb_latency: got %0d, expected 5", obs_resp_cyc); end
    n_tests++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rb_rdata: got %h, expected deadbeef", obs_rdata); end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 32'h0000_0022, 32'h5555_AAAA, 0, 1);
    n_tests++; if (obs_resp_cnt != 1) begin n_fail++; $display("FAIL mis_resp_count: got %0d, expected 1", obs_resp_cnt); end
    n_tests++; if (obs_resp_cyc != 1) begin n_fail++; $display("FAIL mis_latency: got %0d, expected 1", obs_resp_cyc); end
    n_tests++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL mis_error: got %0h, expected 1", obs_err); end
    n_tests++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h, expected 0", obs_rdata); end
    n_tests++; if (obs_start_cnt != 0) begin n_fail++; $display("FAIL mis_no_start: got %0d, expected 0", obs_start_cnt); end
    n_tests++; if (obs_ready_cyc != 3) begin n_fail++; $display("FAIL mis_ready_return: got %0d, expected 3", obs_ready_cyc); end
  endtask

  task automatic test_early_rdy();
    run_access(1'b0, 32'h0000_0020, 32'h0000_0000, 1, 1);
    n_tests++; if (obs_start_cnt != 1) begin n_fail++; $display("FAIL early_start_len: got %0d, expected 1", obs_start_cnt); end
    n_tests++; if (obs_resp_cyc != 2) begin n_fail++; $display("FAIL early_latency: got %0d, expected 2", obs_resp_cyc); end
    n_tests++; if (obs_rdata !== 32'h0016_8693) begin n_fail++; $display("FAIL early_rdata: got %h, expected 00168693", obs_rdata); end
    n_tests++; if (obs_ready_cyc != 4) begin n_fail++; $display("FAIL early_ready_return: got %0d, expected 4", obs_ready_cyc); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 32'h0000_0024, 32'h0000_0000, 0, 1);
    n_tests++; if (obs_resp_cnt != 1) begin n_fail++; $display("FAIL to_resp_count: got %0d, expected 1", obs_resp_cnt); end
    n_tests++; if (obs_resp_cyc != 65) begin n_fail++; $display("FAIL to_latency: got %0d, expected 65", obs_resp_cyc); end
    n_tests++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL to_error: got %0h, expected 1", obs_err); end
    n_tests++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h, expected 0", obs_rdata); end
    n_tests++; if (obs_start_cnt != 2) begin n_fail++; $display("FAIL to_start_len: got %0d, expected 2", obs_start_cnt); end
    n_tests++; if (obs_ready_cyc != 67) begin n_fail++; $display("FAIL to_ready_return: got %0d, expected 67", obs_ready_cyc); end
  endtask

  task automatic test_idle_rdy();
    int resp_seen;
    int start_seen;
    int not_ready;
    resp_seen = 0; start_seen = 0; not_ready = 0;
    memory_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid === 1'b1) resp_seen++;
      if (memory_start === 1'b1) start_seen++;
      if (req_ready !== 1'b1) not_ready++;
    end
    memory_rdy = 1'b0;
    tick();
    n_tests++; if (resp_seen != 0) begin n_fail++; $display("FAIL idle_rdy_resp: got %0d, expected 0", resp_seen); end
    n_tests++; if (start_seen != 0) begin n_fail++; $display("FAIL idle_rdy_start: got %0d, expected 0", start_seen); end
    n_tests++; if (not_ready != 0) begin n_fail++; $display("FAIL idle_rdy_ready: got %0d, expected 0", not_ready); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 32'h0000_0020, 32'h0000_0000, 3, 5);
    n_tests++; if (obs_resp_cyc != 4) begin n_fail++; $display("FAIL hold_latency: got %0d, expected 4", obs_resp_cyc); end
    n_tests++; if (obs_resp_cnt != 1) begin n_fail++; $display("FAIL hold_resp_count: got %0d, expected 1", obs_resp_cnt); end
    n_tests++; if (obs_ready_cyc != 9) begin n_fail++; $display("FAIL hold_recover_exit: got %0d, expected 9", obs_ready_cyc); end
    run_access(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 3, 1);
    n_tests++; if (obs_acc_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_accept: got %0h, expected 1", obs_acc_ok); end
    n_tests++; if (obs_resp_cyc != 4) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d, expected 4", obs_resp_cyc); end
    n_tests++; if (obs_ready_cyc != 6) begin n_fail++; $display("FAIL b2b_wr_ready: got %0d, expected 6", obs_ready_cyc); end
    run_access(1'b0, 32'h0000_0044, 32'h0000_0000, 3, 1);
    n_tests++; if (obs_acc_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_accept: got %0h, expected 1", obs_acc_ok); end
    n_tests++; if (obs_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_rd_rdata: got %h, expected cafef00d", obs_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int resp_seen;
    resp_seen = 0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h0000_0020; req_wdata = 32'h1111_1111;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (resp_valid === 1'b1) resp_seen++;
      tick();
    end
    // Now in the third WAIT cycle.
    n_tests++; if (memory_address !== 32'h0000_0020) begin n_fail++; $display("FAIL mid_addr_before: got %h, expected 00000020", memory_address); end
    reset = 1'b1;
    tick();
    if (resp_valid === 1'b1) resp_seen++;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %0h, expected 0", req_ready); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rdata: got %h, expected 0", resp_rdata); end
    n_tests++; if (memory_address !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h, expected 0", memory_address); end
    n_tests++; if (memory_start !== 1'b0 || memory_write_enable !== 1'b0 || resp_error !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_strobes: got start=%0h we=%0h err=%0h, expected 0 0 0", memory_start, memory_write_enable, resp_error); end
    n_tests++; if (memory_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_bus: got %h, expected 0", memory_data); end
    reset = 1'b0;
    tick();
    if (resp_valid === 1'b1) resp_seen++;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %0h, expected 1", req_ready); end
    n_tests++; if (resp_seen != 0) begin n_fail++; $display("FAIL mid_no_resp: got %0d, expected 0", resp_seen); end
    run_access(1'b0, 32'h0000_0020, 32'h0000_0000, 5, 1);
    n_tests++; if (obs_resp_cyc != 6) begin n_fail++; $display("FAIL mid_next_latency: got %0d, expected 6", obs_resp_cyc); end
    n_tests++; if (obs_rdata !== 32'h0016_8693 || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_next_read: got %h err=%0h, expected 00168693 err=0", obs_rdata, obs_err); end
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0000_0000;
    tb_mem[8] = 32'h0016_8693;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_address = 32'h0; req_wdata = 32'h0; memory_rdy = 1'b0;
    tb_drv_en = 1'b1; tb_drv_data = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_early_rdy();
    test_timeout();
    test_idle_rdy();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
